// File: rtl/affine_agen_pkg.sv
// Shared types and constants for the affine address generator.
//   agen_state_e : sequencer state encoding
//   MAX_DIMS     : upper bound on the number of nested loop dimensions
//   agen_cfg_t   : configuration record (offset, per-dim extent and stride)
//                  sized at DEF_WIDTH / MAX_DIMS
package affine_agen_pkg;

   localparam int MAX_DIMS  = 8;
   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } agen_state_e;

   typedef struct packed {
      logic [DEF_WIDTH-1:0]               offset;
      logic [MAX_DIMS-1:0][DEF_WIDTH-1:0] extent;
      logic [MAX_DIMS-1:0][DEF_WIDTH-1:0] stride;
   } agen_cfg_t;

endpackage

// File: rtl/agen_dim_counter.sv
// One loop dimension of the affine address generator.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : step the count by one
//   clr      : return the count to zero (wins over inc)
//   extent   : iteration count of this dimension, 0 behaves as 1
//   count    : current iteration index
//   at_max   : count is the final index (extent-1)
module agen_dim_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic [WIDTH-1:0] extent,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   logic [WIDTH-1:0] last_idx;

   // A zero extent would underflow to all-ones; pin it to a single iteration.
   assign last_idx = (extent == '0) ? '0 : extent - WIDTH'(1);
   assign at_max   = (count == last_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator. Nested counters (dim 0 innermost)
// step an address accumulator that starts at the configured offset; each
// advance adds the stride of the lowest dimension that has not yet wrapped.
// Addresses stream out over a valid/ready handshake.
//
// Optional feature macro: AGEN_BOUNDS_CHECK_EN adds cfg_limit / addr_oob
// (sticky flag for any handshaked address >= cfg_limit).
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   cfg_load     : capture cfg_* (IDLE only, wins over start)
//   cfg_offset   : base address
//   cfg_extent   : per-dim iteration count, dim d at [d*WIDTH +: WIDTH]
//   cfg_stride   : per-dim address delta, dim d at [d*WIDTH +: WIDTH]
//   start        : begin a sequence (IDLE only)
//   abort        : cancel, back to IDLE without done
//   addr_ready   : consumer accepts addr_out
//   addr_valid   : addr_out is valid
//   addr_out     : current address (registered)
//   addr_last    : addr_out is the final address
//   busy         : sequence in progress
//   done         : one-cycle pulse after the last handshake
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting; config loads and start accepted
// RUN   | presenting addresses, advancing on each handshake
// DONE  | one cycle after the final handshake, done pulsed
module affine_addr_gen
   import affine_agen_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIMS  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_load,
   input  logic [WIDTH-1:0]      cfg_offset,
   input  logic [DIMS*WIDTH-1:0] cfg_extent,
   input  logic [DIMS*WIDTH-1:0] cfg_stride,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  addr_ready,
`ifdef AGEN_BOUNDS_CHECK_EN
   input  logic [WIDTH-1:0]      cfg_limit,
   output logic                  addr_oob,
`endif
   output logic                  addr_valid,
   output logic [WIDTH-1:0]      addr_out,
   output logic                  addr_last,
   output logic                  busy,
   output logic                  done
);

   agen_state_e      state_q;
   logic [WIDTH-1:0] offset_q;
   logic [WIDTH-1:0] extent_q [DIMS];
   logic [WIDTH-1:0] stride_q [DIMS];

   // Counts are only observed through at_max; kept for debug visibility.
   logic [WIDTH-1:0] dim_count_unused [DIMS];
   logic [DIMS-1:0]  at_max;
   logic [DIMS-1:0]  inc_v;
   logic [DIMS-1:0]  clr_v;
   logic [WIDTH-1:0] delta;
   logic             lower_max;
   logic             all_max;
   logic             hs;
   logic             start_go;
   logic             adv;

   assign hs        = addr_valid & addr_ready;
   assign all_max   = &at_max;
   assign addr_last = addr_valid & all_max;
   assign busy      = (state_q == RUN);
   assign start_go  = (state_q == IDLE) & start & ~cfg_load & ~abort;
   assign adv       = (state_q == RUN) & hs & ~all_max & ~abort;

   // Carry chain: the lowest dim not at max increments and supplies the
   // stride; every dim below it is at max and rewinds to zero.
   always_comb begin
      inc_v     = '0;
      clr_v     = '0;
      delta     = '0;
      lower_max = 1'b1;
      for (int d = 0; d < DIMS; d++) begin
         if (lower_max && !at_max[d]) begin
            delta = stride_q[d];
         end
         inc_v[d]  = adv & lower_max & ~at_max[d];
         clr_v[d]  = start_go | (adv & lower_max & at_max[d]);
         lower_max = lower_max & at_max[d];
      end
   end

   for (genvar g = 0; g < DIMS; g++) begin : g_dim
      agen_dim_counter #(.WIDTH(WIDTH)) u_dim (
         .clk    (clk),
         .rst    (rst),
         .inc    (inc_v[g]),
         .clr    (clr_v[g]),
         .extent (extent_q[g]),
         .count  (dim_count_unused[g]),
         .at_max (at_max[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         addr_out   <= '0;
         addr_valid <= 1'b0;
         done       <= 1'b0;
         for (int d = 0; d < DIMS; d++) begin
            extent_q[d] <= '0;
            stride_q[d] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_load) begin
                  offset_q <= cfg_offset;
                  for (int d = 0; d < DIMS; d++) begin
                     extent_q[d] <= cfg_extent[d*WIDTH +: WIDTH];
                     stride_q[d] <= cfg_stride[d*WIDTH +: WIDTH];
                  end
               end else if (start && !abort) begin
                  state_q    <= RUN;
                  addr_valid <= 1'b1;
                  addr_out   <= offset_q;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q    <= IDLE;
                  addr_valid <= 1'b0;
               end else if (hs) begin
                  if (all_max) begin
                     state_q    <= DONE;
                     addr_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     addr_out <= addr_out + delta;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef AGEN_BOUNDS_CHECK_EN
   logic [WIDTH-1:0] limit_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         limit_q  <= '0;
         addr_oob <= 1'b0;
      end else begin
         if (state_q == IDLE && cfg_load) begin
            limit_q <= cfg_limit;
         end
         if (start_go) begin
            addr_oob <= 1'b0;
         end else if (busy && hs && addr_out >= limit_q) begin
            addr_oob <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_affine_addr_gen.sv
module tb_affine_addr_gen;

   localparam int W = 16;
   localparam int D = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_load;
   logic [W-1:0]   cfg_offset;
   logic [D*W-1:0] cfg_extent;
   logic [D*W-1:0] cfg_stride;
   logic           start;
   logic           abort;
   logic           addr_ready;
   logic           addr_valid;
   logic [W-1:0]   addr_out;
   logic           addr_last;
   logic           busy;
   logic           done;
`ifdef AGEN_BOUNDS_CHECK_EN
   logic [W-1:0]   cfg_limit;
   logic           addr_oob;
`endif

   always #5 clk = ~clk;

   affine_addr_gen #(.WIDTH(W), .DIMS(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_load   (cfg_load),
      .cfg_offset (cfg_offset),
      .cfg_extent (cfg_extent),
      .cfg_stride (cfg_stride),
      .start      (start),
      .abort      (abort),
      .addr_ready (addr_ready),
`ifdef AGEN_BOUNDS_CHECK_EN
      .cfg_limit  (cfg_limit),
      .addr_oob   (addr_oob),
`endif
      .addr_valid (addr_valid),
      .addr_out   (addr_out),
      .addr_last  (addr_last),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [W-1:0] off;
      logic [W-1:0] e0;
      logic [W-1:0] e1;
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      int           n;
      logic [W-1:0] exp [8];
   } vec_t;

   vec_t         vecs [5];
   logic [W-1:0] sb [$];
   int           n_vec = 0;
   int           n_mis = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int i);
      cfg_offset = vecs[i].off;
      cfg_extent = {vecs[i].e1, vecs[i].e0};
      cfg_stride = {vecs[i].s1, vecs[i].s0};
   endtask

   task automatic load_cfg(input int i);
      set_cfg(i);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic kick(input int i);
      sb.delete();
      for (int k = 0; k < vecs[i].n; k++) sb.push_back(vecs[i].exp[k]);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating
   task automatic drain(input int mode);
      int           cyc;
      bit           fin;
      bit           held;
      logic [W-1:0] held_addr;
      logic [W-1:0] exp;
      cyc  = 0;
      fin  = 1'b0;
      held = 1'b0;
      held_addr = '0;
      while (!fin && cyc < 60) begin
         addr_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         @(negedge clk);
         check("busy_run", busy, 1);
         check("valid_run", addr_valid, 1);
         if (held) check("hold_addr", addr_out, held_addr);
         held = 1'b0;
         if (addr_valid && addr_ready) begin
            exp = sb.pop_front();
            check("addr", addr_out, exp);
            check("last", addr_last, sb.size() == 0);
            if (sb.size() == 0) fin = 1'b1;
         end else if (addr_valid) begin
            held      = 1'b1;
            held_addr = addr_out;
         end
         tick();
         cyc++;
      end
      if (!fin) check("drain_timeout", 0, 1);
      addr_ready = 1'b0;
      @(negedge clk);
      check("done_pulse", done, 1);
      check("valid_after_last", addr_valid, 0);
      check("busy_in_done", busy, 0);
      tick();
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      tick();
   endtask

   initial begin
      vecs[0] = '{16'd100, 16'd3, 16'd2, 16'd1, 16'd6, 6,
                  '{16'd100, 16'd101, 16'd102, 16'd108, 16'd109, 16'd110, 16'd0, 16'd0}};
      vecs[1] = '{16'hFFFF, 16'd3, 16'd1, 16'd1, 16'd0, 3,
                  '{16'hFFFF, 16'h0000, 16'h0001, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
      vecs[2] = '{16'h0055, 16'd1, 16'd0, 16'd9, 16'd9, 1,
                  '{16'h0055, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
      vecs[3] = '{16'd10, 16'd2, 16'd3, 16'd5, 16'hFFF0, 6,
                  '{16'd10, 16'd15, 16'hFFFF, 16'h0004, 16'hFFF4, 16'hFFF9, 16'd0, 16'd0}};
      vecs[4] = '{16'd0, 16'd0, 16'd4, 16'd7, 16'd3, 4,
                  '{16'd0, 16'd3, 16'd6, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0}};

      rst        = 1'b1;
      cfg_load   = 1'b0;
      cfg_offset = '0;
      cfg_extent = '0;
      cfg_stride = '0;
      start      = 1'b0;
      abort      = 1'b0;
      addr_ready = 1'b0;
`ifdef AGEN_BOUNDS_CHECK_EN
      cfg_limit  = '1;
`endif
      #12;
      check("rst_valid", addr_valid, 0);
      check("rst_addr", addr_out, 0);
      check("rst_last", addr_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      tick();
      rst = 1'b0;
      tick();

      for (int mode = 0; mode < 2; mode++) begin
         for (int i = 0; i < 5; i++) begin
            load_cfg(i);
            kick(i);
            drain(mode);
         end
      end

      // simultaneous load+start: load taken, start dropped
      set_cfg(1);
      cfg_load = 1'b1;
      start    = 1'b1;
      tick();
      cfg_load = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      check("load_start_valid", addr_valid, 0);
      check("load_start_busy", busy, 0);
      tick();
      kick(1);
      drain(0);

      // start and cfg_load while busy are ignored
      load_cfg(0);
      kick(0);
      addr_ready = 1'b0;
      set_cfg(3);
      cfg_load = 1'b1;
      start    = 1'b1;
      tick();
      cfg_load = 1'b0;
      start    = 1'b0;
      drain(0);

      // abort beats a same-cycle handshake
      load_cfg(0);
      kick(0);
      addr_ready = 1'b1;
      tick();
      abort = 1'b1;
      @(negedge clk);
      check("pre_abort_addr", addr_out, 16'd101);
      tick();
      abort      = 1'b0;
      addr_ready = 1'b0;
      @(negedge clk);
      check("abort_valid", addr_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_no_done", done, 0);
      tick();
      @(negedge clk);
      check("abort_no_done2", done, 0);
      tick();
      kick(0);
      drain(0);

      // async reset mid-sequence
      load_cfg(0);
      kick(0);
      addr_ready = 1'b1;
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      check("arst_valid", addr_valid, 0);
      check("arst_addr", addr_out, 0);
      check("arst_busy", busy, 0);
      check("arst_last", addr_last, 0);
      addr_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      // config was cleared: a bare start yields one address of zero
      sb.delete();
      sb.push_back(16'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain(0);

`ifdef AGEN_BOUNDS_CHECK_EN
      set_cfg(0);
      cfg_limit = 16'd105;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      kick(0);
      addr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("oob_step", addr_oob, k >= 4);
         tick();
      end
      addr_ready = 1'b0;
      @(negedge clk);
      check("oob_sticky", addr_oob, 1);
      tick();
      tick();
      kick(0);
      @(negedge clk);
      check("oob_clear_on_start", addr_oob, 0);
      tick();
      drain(0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
